// File: rtl/mem_pkg.sv
// Shared definitions for the system-memory arbiter.
//   state_e             : arbiter FSM states
//   DEF_AW / DEF_DW     : default address / data widths (64K x 8 memory)
//   PORT_CPU / PORT_AUX : port indices (x86 core, secondary bus master)
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        ACK  = 2'd2
    } state_e;

    localparam int DEF_AW   = 16;
    localparam int DEF_DW   = 8;

    localparam int PORT_CPU = 0;
    localparam int PORT_AUX = 1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way picker.
//   eligible_i : per-port eligible request
//   last_i     : port served most recently
//   fixed_i    : 1 = port 0 always wins ties, 0 = alternate on ties
//   valid_o    : at least one port eligible
//   winner_o   : index of the selected port (meaningful when valid_o)
module rr_pick2 (
    input  logic [1:0] eligible_i,
    input  logic       last_i,
    input  logic       fixed_i,
    output logic       valid_o,
    output logic       winner_o
);

    always_comb begin
        valid_o  = |eligible_i;
        // Single requester: port 1 wins only if it is the one asking.
        winner_o = eligible_i[1];
        // Tie: fixed priority favours port 0, otherwise the port not served last.
        if (&eligible_i) begin
            winner_o = fixed_i ? 1'b0 : ~last_i;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single-port synchronous-read system memory.
// Port 0 is the CPU, port 1 a secondary master (video fetch / DMA).
//   clock, reset_n          : rising-edge clock, synchronous active-low reset
//   locked                  : PLL locked; no new grant while low
//   m_req, m_we             : per-port request / write flag (held until ack)
//   m0/m1_address, m0/m1_out: per-port address and write data
//   m0_in, m1_in            : per-port read data, valid in the ack cycle
//   m_ack                   : one-cycle completion pulse per port
//   mem_address/out/we      : registered memory address, write data, strobe
//   mem_in                  : memory read data, one cycle after address
// Each access runs IDLE -> ACC -> ACK; ack appears the cycle after ACK.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int FIXED_PRIO = 0
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          locked,
    input  logic [1:0]    m_req,
    input  logic [1:0]    m_we,
    input  logic [AW-1:0] m0_address,
    input  logic [AW-1:0] m1_address,
    input  logic [DW-1:0] m0_out,
    input  logic [DW-1:0] m1_out,
    output logic [DW-1:0] m0_in,
    output logic [DW-1:0] m1_in,
    output logic [1:0]    m_ack,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_out,
    output logic          mem_we,
    input  logic [DW-1:0] mem_in
);

    localparam logic FIXED = (FIXED_PRIO != 0);
    localparam logic AUX   = 1'(PORT_AUX);

    state_e        state_q;
    logic          g_q;
    logic          last_q;
    logic          wr_q;        // current access is a write; survives mem_we drop
    logic [1:0]    ack_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          we_q;
    logic [DW-1:0] m0_in_q;
    logic [DW-1:0] m1_in_q;

    logic          pick_valid;
    logic          pick_win;
    logic [1:0]    eligible;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] wdata_d;
    logic          we_d;

    // A port is masked during its own ack cycle so its still-high req
    // is not mistaken for a new request.
    assign eligible = m_req & ~ack_q;

    rr_pick2 u_pick (
        .eligible_i (eligible),
        .last_i     (last_q),
        .fixed_i    (FIXED),
        .valid_o    (pick_valid),
        .winner_o   (pick_win)
    );

    always_comb begin
        addr_d  = (pick_win == AUX) ? m1_address : m0_address;
        wdata_d = (pick_win == AUX) ? m1_out     : m0_out;
        we_d    = m_we[pick_win];
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            g_q     <= 1'b0;
            last_q  <= 1'b1;
            wr_q    <= 1'b0;
            ack_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            m0_in_q <= '0;
            m1_in_q <= '0;
        end else begin
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (locked && pick_valid) begin
                        g_q     <= pick_win;
                        addr_q  <= addr_d;
                        wdata_q <= wdata_d;
                        we_q    <= we_d;
                        wr_q    <= we_d;
                        state_q <= ACC;
                    end
                end
                ACC: begin
                    // Memory commits a write at this edge; strobe is one cycle.
                    we_q    <= 1'b0;
                    state_q <= ACK;
                end
                ACK: begin
                    if (!wr_q) begin
                        if (g_q == AUX) m1_in_q <= mem_in;
                        else            m0_in_q <= mem_in;
                    end
                    ack_q[g_q] <= 1'b1;
                    last_q     <= g_q;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_ack       = ack_q;
    assign mem_address = addr_q;
    assign mem_out     = wdata_q;
    assign mem_we      = we_q;
    assign m0_in       = m0_in_q;
    assign m1_in       = m1_in_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: two arbiters (round-robin u0, fixed-priority u1) share the
// same master stimulus, each with its own 64K x 8 synchronous-read memory.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset_n, locked;
    logic [1:0]  m_req, m_we;
    logic [15:0] m0_address, m1_address;
    logic [7:0]  m0_out, m1_out;

    logic [7:0]  u0_m0_in, u0_m1_in, u0_mem_out, u0_mem_in;
    logic [1:0]  u0_m_ack;
    logic [15:0] u0_mem_address;
    logic        u0_mem_we;
    logic [7:0]  u1_m0_in, u1_m1_in, u1_mem_out, u1_mem_in;
    logic [1:0]  u1_m_ack;
    logic [15:0] u1_mem_address;
    logic        u1_mem_we;

    logic [7:0]  mem0 [0:65535];
    logic [7:0]  mem1 [0:65535];
    logic        pre_we;
    logic [15:0] pre_addr;
    logic [7:0]  pre_data;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.AW(16), .DW(8), .FIXED_PRIO(0)) u0 (
        .clock(clock), .reset_n(reset_n), .locked(locked), .m_req(m_req), .m_we(m_we),
        .m0_address(m0_address), .m1_address(m1_address), .m0_out(m0_out), .m1_out(m1_out),
        .m0_in(u0_m0_in), .m1_in(u0_m1_in), .m_ack(u0_m_ack), .mem_address(u0_mem_address),
        .mem_out(u0_mem_out), .mem_we(u0_mem_we), .mem_in(u0_mem_in)
    );

    mem_arbiter #(.AW(16), .DW(8), .FIXED_PRIO(1)) u1 (
        .clock(clock), .reset_n(reset_n), .locked(locked), .m_req(m_req), .m_we(m_we),
        .m0_address(m0_address), .m1_address(m1_address), .m0_out(m0_out), .m1_out(m1_out),
        .m0_in(u1_m0_in), .m1_in(u1_m1_in), .m_ack(u1_m_ack), .mem_address(u1_mem_address),
        .mem_out(u1_mem_out), .mem_we(u1_mem_we), .mem_in(u1_mem_in)
    );

    // Synchronous-read memories; pre_we lets the bench load contents.
    always @(posedge clock) begin
        if (pre_we) begin
            mem0[pre_addr] <= pre_data;
            mem1[pre_addr] <= pre_data;
        end else begin
            if (u0_mem_we) mem0[u0_mem_address] <= u0_mem_out;
            if (u1_mem_we) mem1[u1_mem_address] <= u1_mem_out;
        end
        u0_mem_in <= mem0[u0_mem_address];
        u1_mem_in <= mem1[u1_mem_address];
    end

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pre_addr = a; pre_data = d; pre_we = 1'b1;
        @(negedge clock);
        pre_we = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; locked = 1'b1; m_req = 2'b00; m_we = 2'b00;
        m0_address = '0; m1_address = '0; m0_out = '0; m1_out = '0; pre_we = 1'b0;
        pre_addr = '0; pre_data = '0;
        @(negedge clock);
        preload(16'h1234, 8'hA5); preload(16'hFFFF, 8'h5A);
        preload(16'h0100, 8'h11); preload(16'h0200, 8'h22);
        preload(16'h0A00, 8'h33); preload(16'h0A01, 8'h44);
        preload(16'h0300, 8'h55); preload(16'h0400, 8'h66);
        checks++; if (u0_m_ack !== 2'b00) begin errors++; $display("FAIL reset_ack got %b exp 00", u0_m_ack); end
        checks++; if (u0_mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", u0_mem_we); end
        checks++; if (u0_mem_address !== 16'h0) begin errors++; $display("FAIL reset_addr got %h exp 0000", u0_mem_address); end
        checks++; if (u0_m0_in !== 8'h0 || u0_m1_in !== 8'h0) begin errors++; $display("FAIL reset_rdata got %h/%h exp 00/00", u0_m0_in, u0_m1_in); end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_single_read();
        m0_address = 16'h1234; m_we = 2'b00; m_req = 2'b01;
        @(negedge clock);
        checks++; if (u0_mem_address !== 16'h1234 || u0_mem_we !== 1'b0) begin errors++; $display("FAIL read_acc got %h we %b exp 1234 we 0", u0_mem_address, u0_mem_we); end
        @(negedge clock);
        checks++; if (u0_m_ack !== 2'b00) begin errors++; $display("FAIL read_early_ack got %b exp 00", u0_m_ack); end
        @(negedge clock);
        checks++; if (u0_m_ack !== 2'b01 || u0_m0_in !== 8'hA5) begin errors++; $display("FAIL read_ack got %b/%h exp 01/a5", u0_m_ack, u0_m0_in); end
        m_req = 2'b00;
        @(negedge clock);
        checks++; if (u0_m_ack !== 2'b00) begin errors++; $display("FAIL read_ack_width got %b exp 00", u0_m_ack); end
    endtask

    task automatic test_single_write();
        m1_address = 16'hFFFF; m1_out = 8'h3C; m_we = 2'b10; m_req = 2'b10;
        @(negedge clock);
        checks++; if (u0_mem_we !== 1'b1 || u0_mem_address !== 16'hFFFF || u0_mem_out !== 8'h3C) begin errors++; $display("FAIL write_acc got we %b %h %h exp 1 ffff 3c", u0_mem_we, u0_mem_address, u0_mem_out); end
        @(negedge clock);
        checks++; if (u0_mem_we !== 1'b0) begin errors++; $display("FAIL write_we_width got %b exp 0", u0_mem_we); end
        @(negedge clock);
        checks++; if (u0_m_ack !== 2'b10) begin errors++; $display("FAIL write_ack got %b exp 10", u0_m_ack); end
        checks++; if (u0_m1_in !== 8'h00) begin errors++; $display("FAIL write_rdata_kept got %h exp 00", u0_m1_in); end
        checks++; if (mem0[16'hFFFF] !== 8'h3C) begin errors++; $display("FAIL write_mem got %h exp 3c", mem0[16'hFFFF]); end
        m_req = 2'b00; m_we = 2'b00;
        @(negedge clock);
    endtask

    // Both held: grants 0,1,0,1 with one access every three cycles.
    task automatic test_alternate();
        bit p1;
        m0_address = 16'h0100; m1_address = 16'h0200; m_we = 2'b00; m_req = 2'b11;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clock);
            p1 = (((n - 1) / 3) % 2) == 1;
            if (n % 3 == 1) begin
                checks++; if (u0_mem_address !== (p1 ? 16'h0200 : 16'h0100)) begin errors++; $display("FAIL alt_addr n=%0d got %h exp %h", n, u0_mem_address, p1 ? 16'h0200 : 16'h0100); end
            end else if (n % 3 == 0) begin
                checks++; if (u0_m_ack !== (p1 ? 2'b10 : 2'b01)) begin errors++; $display("FAIL alt_ack n=%0d got %b exp %b", n, u0_m_ack, p1 ? 2'b10 : 2'b01); end
                checks++; if ((p1 ? u0_m1_in : u0_m0_in) !== (p1 ? 8'h22 : 8'h11)) begin errors++; $display("FAIL alt_rdata n=%0d got %h exp %h", n, p1 ? u0_m1_in : u0_m0_in, p1 ? 8'h22 : 8'h11); end
            end else begin
                checks++; if (u0_m_ack !== 2'b00) begin errors++; $display("FAIL alt_noack n=%0d got %b exp 00", n, u0_m_ack); end
            end
        end
        m_req = 2'b00;
        @(negedge clock);
        @(negedge clock);
    endtask

    // Fixed priority, port 0 held: port 1 gets in only while port 0 is masked.
    task automatic test_fixed_hold();
        bit p1;
        m0_address = 16'h0200; m1_address = 16'h0100; m_we = 2'b00; m_req = 2'b11;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clock);
            p1 = (((n - 1) / 3) % 2) == 1;
            if (n % 3 == 1) begin
                checks++; if (u1_mem_address !== (p1 ? 16'h0100 : 16'h0200)) begin errors++; $display("FAIL fix_addr n=%0d got %h exp %h", n, u1_mem_address, p1 ? 16'h0100 : 16'h0200); end
            end else if (n % 3 == 0) begin
                checks++; if (u1_m_ack !== (p1 ? 2'b10 : 2'b01)) begin errors++; $display("FAIL fix_ack n=%0d got %b exp %b", n, u1_m_ack, p1 ? 2'b10 : 2'b01); end
                checks++; if ((p1 ? u1_m1_in : u1_m0_in) !== (p1 ? 8'h11 : 8'h22)) begin errors++; $display("FAIL fix_rdata n=%0d got %h exp %h", n, p1 ? u1_m1_in : u1_m0_in, p1 ? 8'h11 : 8'h22); end
            end
        end
        m_req = 2'b00;
        @(negedge clock);
        @(negedge clock);
    endtask

    // After port 0 is served, a fresh tie goes to port 1 (RR) or port 0 (fixed).
    // Requests drop right after the grant; the accesses still complete.
    task automatic test_tie();
        m0_address = 16'h0A00; m1_address = 16'h0A01; m_we = 2'b00; m_req = 2'b01;
        repeat (3) @(negedge clock);
        checks++; if (u0_m_ack !== 2'b01 || u1_m_ack !== 2'b01) begin errors++; $display("FAIL tie_pre_ack got %b/%b exp 01/01", u0_m_ack, u1_m_ack); end
        m_req = 2'b00;
        @(negedge clock);
        m_req = 2'b11;
        @(negedge clock);
        checks++; if (u0_mem_address !== 16'h0A01) begin errors++; $display("FAIL tie_rr_addr got %h exp 0a01", u0_mem_address); end
        checks++; if (u1_mem_address !== 16'h0A00) begin errors++; $display("FAIL tie_fix_addr got %h exp 0a00", u1_mem_address); end
        m_req = 2'b00;
        repeat (2) @(negedge clock);
        checks++; if (u0_m_ack !== 2'b10 || u0_m1_in !== 8'h44) begin errors++; $display("FAIL tie_rr_ack got %b/%h exp 10/44", u0_m_ack, u0_m1_in); end
        checks++; if (u1_m_ack !== 2'b01 || u1_m0_in !== 8'h33) begin errors++; $display("FAIL tie_fix_ack got %b/%h exp 01/33", u1_m_ack, u1_m0_in); end
        @(negedge clock);
    endtask

    task automatic test_locked();
        locked = 1'b0; m0_address = 16'h0300; m1_address = 16'h0400; m_we = 2'b00; m_req = 2'b11;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clock);
            checks++; if (u0_m_ack !== 2'b00 || u0_mem_we !== 1'b0 || u0_mem_address !== 16'h0A01) begin errors++; $display("FAIL lock_hold n=%0d got ack %b we %b addr %h exp 00 0 0a01", n, u0_m_ack, u0_mem_we, u0_mem_address); end
        end
        locked = 1'b1;
        @(negedge clock);
        checks++; if (u0_mem_address !== 16'h0300 || u1_mem_address !== 16'h0300) begin errors++; $display("FAIL lock_grant got %h/%h exp 0300/0300", u0_mem_address, u1_mem_address); end
        m_req = 2'b00;
        repeat (2) @(negedge clock);
        checks++; if (u0_m_ack !== 2'b01 || u0_m0_in !== 8'h55) begin errors++; $display("FAIL lock_ack got %b/%h exp 01/55", u0_m_ack, u0_m0_in); end
        @(negedge clock);
    endtask

    task automatic test_reset_mid_write();
        m0_address = 16'h0010; m0_out = 8'h77; m_we = 2'b01; m_req = 2'b01;
        @(negedge clock);
        checks++; if (u0_mem_we !== 1'b1) begin errors++; $display("FAIL rst_wr_acc got we %b exp 1", u0_mem_we); end
        reset_n = 1'b0; m_req = 2'b00; m_we = 2'b00;
        @(negedge clock);
        checks++; if (mem0[16'h0010] !== 8'h77) begin errors++; $display("FAIL rst_wr_mem got %h exp 77", mem0[16'h0010]); end
        checks++; if (u0_m_ack !== 2'b00 || u0_mem_we !== 1'b0 || u0_mem_address !== 16'h0 || u0_mem_out !== 8'h0) begin errors++; $display("FAIL rst_wr_outs got %b %b %h %h exp 00 0 0000 00", u0_m_ack, u0_mem_we, u0_mem_address, u0_mem_out); end
        checks++; if (u0_m0_in !== 8'h0 || u0_m1_in !== 8'h0) begin errors++; $display("FAIL rst_wr_rdata got %h/%h exp 00/00", u0_m0_in, u0_m1_in); end
        reset_n = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clock);
            checks++; if (u0_m_ack !== 2'b00 || u0_mem_we !== 1'b0) begin errors++; $display("FAIL rst_wr_noack n=%0d got %b we %b exp 00 0", n, u0_m_ack, u0_mem_we); end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_alternate();
        test_fixed_hold();
        test_tie();
        test_locked();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port 64K×8 system memory between the x86 core (port 0) and a secondary bus master such as video fetch or DMA (port 1). Each port uses a req/ack handshake. The arbiter serialises accesses, drives the memory's registered address/data/write-enable lines, and returns read data on the memory's 1-cycle synchronous-read timing. It sits between the masters and the memory array in the top level.

## Interface
- `AW`, 16: address width
- `DW`, 8: data width
- `FIXED_PRIO`, 0: 0 = round-robin; 1 = port 0 always wins ties
- `clock` in 1: system clock; all logic on rising edge
- `reset_n` in 1: reset, synchronous, active-low
- `locked` in 1: PLL locked; while low, no new grant is issued
- `m_req` in 2: per-port request; held with fields stable until ack
- `m_we` in 2: per-port write flag
- `m0_address`, `m1_address` in AW: request addresses
- `m0_out`, `m1_out` in DW: write data
- `m0_in`, `m1_in` out DW: read data, registered, valid in the ack cycle
- `m_ack` out 2: one-cycle completion pulse per port
- `mem_address` out AW: memory address, registered
- `mem_out` out DW: memory write data, registered
- `mem_we` out 1: memory write strobe, registered
- `mem_in` in DW: memory read data, valid one cycle after address

## Operation
- FSM states: IDLE, ACC, ACK. Register `g` holds the current grantee; register `last` holds the last port served.
- **IDLE**
  - Eligible requests are `m_req & ~m_ack`. A port's req is masked during its own ack cycle.
  - If no eligible request, or `locked` = 0: stay in IDLE.
  - Otherwise pick the winner:
    - Only one eligible port: that port wins.
    - Both eligible, FIXED_PRIO = 0: the port != `last` wins.
    - Both eligible, FIXED_PRIO = 1: port 0 wins.
  - On the winning edge: latch `g`, `mem_address`, `mem_out`, and `mem_we` = `m_we[g]`; go to ACC.
- **ACC**
  - Memory samples address/we during this cycle; a write commits at the closing edge.
  - At the edge: `mem_we` <= 0; go to ACK.
- **ACK**
  - `mem_in` is valid in this cycle.
  - At the edge:
    - if a read, `mX_in[g]` <= `mem_in`; on writes `mX_in` is unchanged;
    - `m_ack[g]` <= 1;
    - `last` <= `g`;
    - go to IDLE.
- `m_ack` is cleared at the edge following every edge that set it.
- A requester must keep address, data and we stable from req rise until ack is seen.

## Timing
- Reset values: state IDLE, `last` = 1 (port 0 wins the first tie), `g` = 0, `m_ack` = 0, `mem_we` = 0, `mem_address` = 0, `mem_out` = 0, `m0_in` = `m1_in` = 0.
- Latency: req sampled at edge E, then `mem_*` valid in cycle E+1 (ACC), then `m_ack` high in cycle E+3.
  - The arbiter is back in IDLE during the ack cycle, so the other port can be granted at that edge.
- Throughput:
  - Two ports alternating: one access per 3 cycles.
  - Single port: one access per 4 cycles, because of the ack-cycle mask.
- `mem_we` is exactly one cycle wide, only in ACC.
- `locked` falling during ACC or ACK: the in-flight access completes and acks normally.
- Reset during ACC: the memory write still commits, since the strobe was already driven that cycle. State and outputs clear at the edge and no ack is issued.
- Reset during ACK: no ack; read data is discarded.
- Request withdrawn before grant: not an error; nothing happens.
- Request withdrawn after grant: the access still completes and acks.

## Structure
- Shared package `mem_pkg`:
  - state enum {IDLE, ACC, ACK};
  - default AW/DW constants;
  - port index constants PORT_CPU = 0, PORT_AUX = 1.
- Sub-module `rr_pick2`: combinational 2-way picker.
  - Inputs: eligible[1:0], last, fixed.
  - Outputs: valid, winner.
- Everything else (FSM, data registers) lives in `mem_arbiter`.

## Test plan
- **Single read:** memory[0x1234] = 0xA5, port 0 read at 0x1234.
  - `mem_address` = 0x1234 in cycle E+1.
  - `m_ack` = 01 and `m0_in` = 0xA5 in cycle E+3.
- **Single write:** port 1 writes 0x3C to 0xFFFF.
  - `mem_we` high for exactly one cycle.
  - memory[0xFFFF] = 0x3C.
  - `m_ack` = 10 at E+3; `m1_in` unchanged.
- **Simultaneous requests, FIXED_PRIO = 0, both held:**
  - Grant order is 0, 1, 0, 1.
  - Acks 3 cycles apart.
  - Each port's address reaches `mem_address` only on its own grants.
- **Simultaneous requests, FIXED_PRIO = 1, port 0 held continuously:**
  - Port 1 is granted only in cycles where port 0 is masked by its ack.
  - The bench checks that port 1 still completes.
- **`locked` = 0 with req = 11:**
  - No `mem_we`, no ack, state stays IDLE.
  - Raising `locked` gives a grant on the next edge.
- **Reset mid-write:** reset_n = 0 in the ACC cycle of a write of 0x77 to 0x0010.
  - memory[0x0010] = 0x77.
  - No ack.
  - All outputs at reset values after the edge.
